// File: rtl/bus_arb_protocol_monitor_if.sv
// Request/grant/frame/irdy bus bundle shared by the arbiter side and the passive monitor.
interface bus_arb_protocol_monitor_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               frame;
  logic               irdy;

  modport master (output req, output gnt, output frame, output irdy);
  modport slave  (input  req, input  gnt, input  frame, input  irdy);
endinterface

// File: rtl/bus_arb_protocol_monitor.sv
// Passive request/grant/frame/irdy protocol checker with sticky flags and saturating counters.
// Define BUS_ARB_MON_SVA_EN to add concurrent assertions and covers mirroring each check.
module bus_arb_protocol_monitor #(
  parameter int NUM_REQ = 4,
  parameter int GNT_MIN = 3,
  parameter int GNT_MAX = 6,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bus_arb_protocol_monitor_if.slave   bus,
  input  logic                        clr,
  output logic [NUM_REQ-1:0]          err_lat,
  output logic                        err_frame,
  output logic                        err_release,
  output logic                        err_onehot,
  output logic                        viol,
  output logic [CNT_W-1:0]            viol_cnt,
  output logic [CNT_W-1:0]            pass_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, GRANTED} state_t;

  localparam logic [7:0] GMIN = 8'(GNT_MIN);
  localparam logic [7:0] GMAX = 8'(GNT_MAX);

  logic [NUM_REQ-1:0] req_q, gnt_q;
  logic               frame_q, irdy_q, arm_q;

  logic [NUM_REQ-1:0] req_rise, gnt_rise, gnt_fall;
  logic               frame_fall, irdy_fall, frame_rise, irdy_rise;

  state_t             state_q [NUM_REQ];
  state_t             state_d [NUM_REQ];
  logic [NUM_REQ-1:0][7:0] lat_q, lat_d;
  logic [NUM_REQ-1:0] lat_fail, pass;

  logic               frame_fail, release_fail, onehot_fail, any_fail;
  logic [4:0]         pass_sum;
  logic [CNT_W+4:0]   pass_acc;
  logic [CNT_W-1:0]   pass_next, viol_next;

  assign req_rise   = bus.req & ~req_q;
  assign gnt_rise   = bus.gnt & ~gnt_q;
  assign gnt_fall   = ~bus.gnt & gnt_q;
  assign frame_fall = ~bus.frame & frame_q;
  assign irdy_fall  = ~bus.irdy & irdy_q;
  assign frame_rise = bus.frame & ~frame_q;
  assign irdy_rise  = bus.irdy & ~irdy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      gnt_q   <= '0;
      frame_q <= 1'b1;
      irdy_q  <= 1'b1;
      arm_q   <= 1'b0;
    end else begin
      req_q   <= bus.req;
      gnt_q   <= bus.gnt;
      frame_q <= bus.frame;
      irdy_q  <= bus.irdy;
      arm_q   <= frame_rise & irdy_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) state_q[i] <= IDLE;
      lat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) state_q[i] <= state_d[i];
      lat_q <= lat_d;
    end
  end

  // lat_d carries the cycle count since the request rise; a grant wins over a dropped request
  always_comb begin
    lat_d    = lat_q;
    lat_fail = '0;
    pass     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: begin
          if (req_rise[i]) begin
            state_d[i] = WAIT;
            lat_d[i]   = 8'd0;
          end
        end
        WAIT: begin
          lat_d[i] = lat_q[i] + 8'd1;
          if (bus.gnt[i]) begin
            state_d[i] = GRANTED;
            if (lat_d[i] < GMIN) lat_fail[i] = 1'b1;
            else                 pass[i]     = 1'b1;
          end else if (lat_d[i] == GMAX) begin
            lat_fail[i] = 1'b1;
            state_d[i]  = IDLE;
          end else if (!bus.req[i]) begin
            state_d[i] = IDLE;
          end
        end
        GRANTED: begin
          if (!bus.gnt[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  assign frame_fail   = (|gnt_rise) && !(frame_fall && irdy_fall);
  assign release_fail = arm_q && !(|gnt_fall);
  assign onehot_fail  = $countones(bus.gnt) > 1;
  assign any_fail     = (|lat_fail) | frame_fail | release_fail | onehot_fail;

  assign pass_sum  = 5'($countones(pass));
  assign pass_acc  = {5'b0, pass_cnt} + {{CNT_W{1'b0}}, pass_sum};
  assign pass_next = (|pass_acc[CNT_W+4:CNT_W]) ? {CNT_W{1'b1}} : pass_acc[CNT_W-1:0];
  assign viol_next = !any_fail ? viol_cnt :
                     (&viol_cnt) ? viol_cnt : viol_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // clr wipes history but a violation seen in the same cycle survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_lat     <= '0;
      err_frame   <= 1'b0;
      err_release <= 1'b0;
      err_onehot  <= 1'b0;
      viol        <= 1'b0;
      viol_cnt    <= '0;
      pass_cnt    <= '0;
    end else if (clr) begin
      err_lat     <= lat_fail;
      err_frame   <= frame_fail;
      err_release <= release_fail;
      err_onehot  <= onehot_fail;
      viol        <= any_fail;
      viol_cnt    <= {{(CNT_W-1){1'b0}}, any_fail};
      pass_cnt    <= '0;
    end else begin
      err_lat     <= err_lat | lat_fail;
      err_frame   <= err_frame | frame_fail;
      err_release <= err_release | release_fail;
      err_onehot  <= err_onehot | onehot_fail;
      viol        <= any_fail;
      viol_cnt    <= viol_next;
      pass_cnt    <= pass_next;
    end
  end

`ifdef BUS_ARB_MON_SVA_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lat_sva
    a_lat_window: assert property (@(posedge clk) disable iff (!rst_n) !lat_fail[g])
      else $error("latency window violation on channel %0d", g);
    c_lat_pass: cover property (@(posedge clk) disable iff (!rst_n) pass[g]);
  end

  a_frame: assert property (@(posedge clk) disable iff (!rst_n) !frame_fail)
    else $error("grant rose without frame and irdy falling");
  c_frame: cover property (@(posedge clk) disable iff (!rst_n) |gnt_rise);

  a_release: assert property (@(posedge clk) disable iff (!rst_n) !release_fail)
    else $error("frame/irdy release not followed by a grant fall");
  c_release: cover property (@(posedge clk) disable iff (!rst_n) arm_q);

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) !onehot_fail)
    else $error("more than one grant active");
  c_onehot: cover property (@(posedge clk) disable iff (!rst_n) $countones(bus.gnt) == 1);
`endif

endmodule
